term_stim_pacer: RTL and testbench

//  Buffered, rate-paced byte source feeding the terminal bench request/data pair
//  (one-cycle req pulse qualifying an 8-bit data byte, sampled on posedge clk).

---
 rtl/term_stim_pacer.sv | 189 ++++++++++++++++++
 tb/tb_term_stim_pacer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/term_stim_pacer.sv
// term_stim_pacer
//   Buffered, rate-paced byte source for the terminal bench req/data pair.
//   The host pushes bytes into a circular FIFO. The pacer releases one byte per
//   one-cycle req pulse. After each pulse it waits a programmable idle gap, so the
//   downstream UART writer is never overrun.
//
//   Optional feature (compile-time macro TERM_STIM_CRLF_EN):
//     Each 8'h0A at the FIFO head is preceded by an 8'h0D pulse. The 0D pulse does
//     not pop the FIFO, and the gap applies after both pulses. When the macro is
//     undefined, bytes pass through unchanged.
//
//   Ports
//     clk        stimulus clock; all logic on the rising edge
//     rst_n      asynchronous active-low reset
//     en         1 = issue bytes, 0 = hold (pushes are still accepted)
//     gap        idle cycles after each req pulse; sampled only at issue
//     push       write push_data into the FIFO this cycle
//     push_data  byte to enqueue
//     full       FIFO full (registered)
//     empty      FIFO empty (registered)
//     level      FIFO occupancy, 0..DEPTH
//     overflow   sticky: a push was seen while full; cleared only by reset
//     busy       in GAP, or a CR is pending
//     req        one-cycle strobe qualifying data
//     data       byte qualified by req; holds its last value otherwise
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready to issue the head byte when en && !empty
//   GAP   | counting down the sampled gap; returns to IDLE at cnt==1
module term_stim_pacer #(
  parameter int DEPTH = 8,
  parameter int GAP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [GAP_W-1:0]       gap,
  input  logic                   push,
  input  logic [7:0]             push_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy,
  output logic                   req,
  output logic [7:0]             data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = (AW)'(1);
  localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [GAP_W-1:0] CNT_ONE  = (GAP_W)'(1);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;
  logic             push_ok;
  logic             pop;
  logic [7:0]       head;

  state_t           state;
  state_t           state_nxt;
  logic [GAP_W-1:0] cnt;
  logic [GAP_W-1:0] cnt_nxt;
  logic             req_nxt;
  logic [7:0]       data_nxt;

  // ---------------- FIFO ----------------
  // A full FIFO drops the push even when a pop happens on the same edge.
  assign push_ok = push && !full;
  assign head    = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push_ok && !pop)
      level_nxt = level + LVL_ONE;
    else if (!push_ok && pop)
      level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  // empty falls one edge after the first write into an empty FIFO. This gives the
  // two-edge push-to-req latency. empty rises on the same edge that pops the last
  // byte, so an empty FIFO is never issued from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push && full)
        overflow <= 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level == '0) || (level_nxt == '0);
    end
  end

  // ---------------- pacer FSM ----------------
`ifdef TERM_STIM_CRLF_EN
  logic cr_pending;
  logic cr_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      req   <= 1'b0;
      data  <= 8'h00;
`ifdef TERM_STIM_CRLF_EN
      cr_pending <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      req   <= req_nxt;
      data  <= data_nxt;
`ifdef TERM_STIM_CRLF_EN
      cr_pending <= cr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = 1'b0;
    data_nxt  = data;
    pop       = 1'b0;
`ifdef TERM_STIM_CRLF_EN
    cr_nxt    = cr_pending;
`endif
    case (state)
      S_IDLE: begin
        if (en && !empty) begin
          req_nxt = 1'b1;
          cnt_nxt = gap;
`ifdef TERM_STIM_CRLF_EN
          if (head == 8'h0A && !cr_pending) begin
            // The LF stays at the head and is sent by the next issue.
            data_nxt = 8'h0D;
            cr_nxt   = 1'b1;
          end else begin
            data_nxt = head;
            pop      = 1'b1;
            cr_nxt   = 1'b0;
          end
`else
          data_nxt = head;
          pop      = 1'b1;
`endif
          if (gap != '0)
            state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == CNT_ONE)
          state_nxt = S_IDLE;
        else
          cnt_nxt = cnt - CNT_ONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef TERM_STIM_CRLF_EN
  assign busy = (state == S_GAP) || cr_pending;
`else
  assign busy = (state == S_GAP);
`endif

endmodule

// File: tb/tb_term_stim_pacer.sv
module tb_term_stim_pacer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] gap = '0;
  logic        push = 1'b0;
  logic [7:0]  push_data = '0;
  logic        full, empty, overflow, busy, req;
  logic [3:0]  level;
  logic [7:0]  data;

  term_stim_pacer #(.DEPTH(DEPTH), .GAP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .gap(gap), .push(push),
    .push_data(push_data), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .busy(busy), .req(req), .data(data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int mon_edge = 0;
  bit mon_on = 1'b1;

  typedef struct { logic [7:0] b; int rdy; } ent_t;
  typedef struct { int e; logic [7:0] b; } req_t;
  typedef struct { int lvl; bit fl; bit ovf; bit emp; bit bsy; logic [7:0] d; } st_t;

  // Reference model: the FIFO is a queue of bytes, each with the earliest edge at
  // which it may be issued. Issues obey the gap+1 spacing rule.
  ent_t mq[$];
  req_t req_q[$];
  st_t  st_q[$];
  int   m_edge = 0;
  int   m_next = 0;
  bit   m_ovf = 1'b0;
  bit   m_cr = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, mon_edge);
  endtask

  task automatic model_step();
    int   pre;
    ent_t h;
    ent_t n;
    req_t r;
    st_t  s;
    logic [7:0] e;
    m_edge++;
    pre = mq.size();
    if (en && m_edge >= m_next && pre > 0 && mq[0].rdy <= m_edge) begin
      h = mq[0];
      e = h.b;
`ifdef TERM_STIM_CRLF_EN
      if (h.b == 8'h0A && !m_cr) begin
        e = 8'h0D;
        m_cr = 1'b1;
      end else begin
        void'(mq.pop_front());
        m_cr = 1'b0;
      end
`else
      void'(mq.pop_front());
`endif
      m_data = e;
      m_next = m_edge + int'(gap) + 1;
      r.e = m_edge;
      r.b = e;
      req_q.push_back(r);
    end
    if (push) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else begin
        n.b = push_data;
        n.rdy = (pre == 0) ? m_edge + 2 : m_edge + 1;
        mq.push_back(n);
      end
    end
    s.lvl = mq.size();
    s.fl  = (mq.size() == DEPTH);
    s.ovf = m_ovf;
    s.emp = (mq.size() == 0) || (pre == 0);
    s.bsy = (m_edge + 2 <= m_next) || m_cr;
    s.d   = m_data;
    st_q.push_back(s);
  endtask

  task automatic tick(input logic e, input logic [15:0] g, input logic p, input logic [7:0] d);
    @(negedge clk);
    en = e;
    gap = g;
    push = p;
    push_data = d;
    model_step();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    push = 1'b0;
    en = 1'b0;
    #1;
    check("rst_req", 32'(req), 32'(0));
    check("rst_data", 32'(data), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_level", 32'(level), 32'(0));
    check("rst_full", 32'(full), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    mq.delete();
    req_q.delete();
    st_q.delete();
    m_edge = 0;
    m_next = 0;
    m_ovf = 1'b0;
    m_cr = 1'b0;
    m_data = 8'h00;
    mon_edge = 0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_step();
  endtask

  // Monitor: compares the DUT against the model entries queued by the driver.
  always @(posedge clk) begin
    st_t  s;
    req_t r;
    #1;
    if (rst_n && mon_on) begin
      mon_edge++;
      if (st_q.size() == 0) begin
        n_chk++;
        $display("FAIL model_sync: no expected state for edge %0d", mon_edge);
      end else begin
        s = st_q.pop_front();
        check("level", 32'(level), 32'(s.lvl));
        check("full", 32'(full), 32'(s.fl));
        check("overflow", 32'(overflow), 32'(s.ovf));
        check("empty", 32'(empty), 32'(s.emp));
        check("busy", 32'(busy), 32'(s.bsy));
        check("data_hold", 32'(data), 32'(s.d));
      end
      if (req) begin
        if (req_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_req: got data %0h with no req expected (edge %0d)", data, mon_edge);
        end else begin
          r = req_q.pop_front();
          check("req_edge", 32'(mon_edge), 32'(r.e));
          check("req_data", 32'(data), 32'(r.b));
        end
      end else if (req_q.size() > 0 && req_q[0].e <= mon_edge) begin
        r = req_q.pop_front();
        n_chk++;
        $display("FAIL missing_req: got none expected data %0h at edge %0d", r.b, r.e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    // 1: reset, then idle with no pushes
    do_reset(3);
    repeat (20) tick(1'b1, 16'd3, 1'b0, 8'h00);
    // 2: gap=3, three bytes
    tick(1'b1, 16'd3, 1'b1, 8'h41);
    tick(1'b1, 16'd3, 1'b1, 8'h42);
    tick(1'b1, 16'd3, 1'b1, 8'h43);
    repeat (16) tick(1'b1, 16'd3, 1'b0, 8'h00);
    // 3: gap=0, back-to-back
    for (int i = 0; i < 4; i++) tick(1'b1, 16'd0, 1'b1, 8'(8'h10 + i));
    repeat (8) tick(1'b1, 16'd0, 1'b0, 8'h00);
    // 4: overfill with en=0, then drain
    for (int i = 0; i < 9; i++) tick(1'b0, 16'd0, 1'b1, 8'(i));
    repeat (3) tick(1'b0, 16'd0, 1'b0, 8'h00);
    repeat (14) tick(1'b1, 16'd0, 1'b0, 8'h00);
    // 5: reset in the middle of a long gap
    do_reset(2);
    tick(1'b1, 16'd10, 1'b1, 8'h77);
    repeat (6) tick(1'b1, 16'd10, 1'b0, 8'h00);
    do_reset(2);
    tick(1'b1, 16'd0, 1'b1, 8'h55);
    repeat (6) tick(1'b1, 16'd0, 1'b0, 8'h00);
    // 6: line feed
    tick(1'b1, 16'd2, 1'b1, 8'h0A);
    repeat (8) tick(1'b1, 16'd2, 1'b0, 8'h00);
    // random traffic, with one reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(2);
      d = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      tick(($urandom_range(0, 7) != 0), 16'($urandom_range(0, 4)),
           ($urandom_range(0, 1) == 1), d);
    end
    repeat (40) tick(1'b1, 16'd0, 1'b0, 8'h00);
    @(negedge clk);
    mon_on = 1'b0;
    check("drain_req_q", 32'(req_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
